fifo_stream_arbiter: RTL

FIFO_STREAM_ARBITER -- requirements
Module: fifo_stream_arbiter

---
 rtl/fifo_stream_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_stream_arbiter
// Description : Two-requester burst arbiter feeding a single Avalon-ST sink.
//               A burst is a one-beat header followed by up to BURST_LEN
//               beats passed straight through from the granted channel.
//               Bursts alternate between channels on contention. A burst
//               whose channel stays idle for TIMEOUT cycles is closed early
//               and counted.
//
// Ports       : clk_clk            - clock, rising edge
//               reset_reset        - synchronous active-high reset
//               enable             - allow new bursts to be granted
//               ch0_valid/data/ready - requester 0 stream sink
//               ch1_valid/data/ready - requester 1 stream sink
//               out_valid/data/ready - merged stream source
//               grant              - channel owning the current burst
//               busy               - header or data phase in progress
//               early_term_count   - saturating count of timed-out bursts
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_arbiter #(
    parameter int          BURST_LEN = 16,
    parameter int          TIMEOUT   = 64,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enable,

    input  logic        ch0_valid,
    input  logic [31:0] ch0_data,
    output logic        ch0_ready,

    input  logic        ch1_valid,
    input  logic [31:0] ch1_data,
    output logic        ch1_ready,

    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,

    output logic        grant,
    output logic        busy,
    output logic [15:0] early_term_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_HDR    = 2'd1;
    localparam logic [1:0]  c_ST_DATA   = 2'd2;

    localparam logic [7:0]  c_BEAT_LAST = 8'(BURST_LEN - 1);
    localparam logic [15:0] c_IDLE_LAST = 16'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [15:0] r_seq0;
    logic [15:0] r_seq1;
    logic [7:0]  r_beat_cnt;
    logic [15:0] r_idle_cnt;
    logic [15:0] r_early_cnt;

    // ------------------------------------------------------------------------
    // Granted-channel selection and header assembly
    // ------------------------------------------------------------------------
    logic        w_sel_valid;
    logic [31:0] w_sel_data;
    logic [15:0] w_sel_seq;
    logic [31:0] w_hdr_word;
    logic        w_xfer;
    logic        w_any_req;
    logic        w_pick;

    assign w_sel_valid = r_grant ? ch1_valid : ch0_valid;
    assign w_sel_data  = r_grant ? ch1_data  : ch0_data;
    assign w_sel_seq   = r_grant ? r_seq1    : r_seq0;
    assign w_hdr_word  = {SYNC_BYTE, 7'd0, r_grant, w_sel_seq};

    assign w_xfer      = out_valid & out_ready;
    assign w_any_req   = ch0_valid | ch1_valid;

    // On contention the channel that did not own the previous burst wins;
    // otherwise the single requesting channel is taken.
    assign w_pick = (ch0_valid & ch1_valid) ? ~r_last_grant : ch1_valid;

    // ------------------------------------------------------------------------
    // Output decode. The data phase is a zero-latency pass-through, so the
    // stream outputs are decoded from the registered state and grant rather
    // than registered themselves; they stay stable under backpressure
    // because neither the state, the grant nor the sequence number moves
    // until a transfer occurs.
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_data  = 32'd0;
        ch0_ready = 1'b0;
        ch1_ready = 1'b0;
        case (r_state)
            c_ST_HDR: begin
                out_valid = 1'b1;
                out_data  = w_hdr_word;
            end
            c_ST_DATA: begin
                out_valid = w_sel_valid;
                out_data  = w_sel_data;
                ch0_ready = out_ready & ~r_grant;
                ch1_ready = out_ready &  r_grant;
            end
            default: begin
                out_valid = 1'b0;
                out_data  = 32'd0;
            end
        endcase
    end

    assign grant            = r_grant;
    assign busy             = (r_state != c_ST_IDLE);
    assign early_term_count = r_early_cnt;

    // ------------------------------------------------------------------------
    // Burst control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= 1'b0;
            // Pretend channel 1 went last so channel 0 wins the first tie.
            r_last_grant <= 1'b1;
            r_seq0       <= 16'd0;
            r_seq1       <= 16'd0;
            r_beat_cnt   <= 8'd0;
            r_idle_cnt   <= 16'd0;
            r_early_cnt  <= 16'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // enable only gates the start of a burst.
                    if (enable && w_any_req) begin
                        r_grant <= w_pick;
                        r_state <= c_ST_HDR;
                    end
                end

                c_ST_HDR: begin
                    if (w_xfer) begin
                        if (r_grant) begin
                            r_seq1 <= r_seq1 + 16'd1;
                        end else begin
                            r_seq0 <= r_seq0 + 16'd1;
                        end
                        r_beat_cnt <= 8'd0;
                        r_idle_cnt <= 16'd0;
                        r_state    <= c_ST_DATA;
                    end
                end

                c_ST_DATA: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        r_idle_cnt <= 16'd0;
                        if (r_beat_cnt == c_BEAT_LAST) begin
                            r_last_grant <= r_grant;
                            r_state      <= c_ST_IDLE;
                        end
                    end else if (!w_sel_valid) begin
                        // Only an empty requester counts as idle; a stalled
                        // sink (valid but not ready) never ends a burst.
                        if (r_idle_cnt == c_IDLE_LAST) begin
                            r_last_grant <= r_grant;
                            r_idle_cnt   <= 16'd0;
                            r_state      <= c_ST_IDLE;
                            if (r_early_cnt != 16'hFFFF) begin
                                r_early_cnt <= r_early_cnt + 16'd1;
                            end
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
